// File: rtl/seg_scan_sched_if.sv
// Write-request bus between the two digit requesters and the scan scheduler.
// Each requester holds req with digit/value until it sees its one-cycle ack.
interface seg_scan_sched_if;
    logic       req0;
    logic [1:0] wr0_digit;
    logic [4:0] wr0_val;
    logic       ack0;
    logic       req1;
    logic [1:0] wr1_digit;
    logic [4:0] wr1_val;
    logic       ack1;

    modport master (
        output req0, wr0_digit, wr0_val, req1, wr1_digit, wr1_val,
        input  ack0, ack1
    );

    modport slave (
        input  req0, wr0_digit, wr0_val, req1, wr1_digit, wr1_val,
        output ack0, ack1
    );
endinterface

// File: rtl/seg_scan_sched.sv
// Seven-segment scan scheduler: round-robin write arbiter, 4x5 digit buffer, guarded scan FSM.
// Define SEG_DIM_EN to add the bright[2:0] input and per-slot PWM dimming.
module seg_scan_sched #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned GUARD_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              lzs_en,
`ifdef SEG_DIM_EN
    input  logic [2:0]        bright,
`endif
    seg_scan_sched_if.slave   wr,
    output logic [1:0]        sel,
    output logic [3:0]        x,
    output logic [3:0]        AN
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LastCnt  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] GuardEnd = PW'(GUARD_CYC - 1);

    typedef enum logic [1:0] {StIdle, StGuard, StDrive} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    x_q, x_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          rr_q, rr_d;
    logic [4:0]    dig_q [4];
    logic [4:0]    dig_d [4];

    logic          vld0, vld1, gnt0, gnt1;
    logic [3:0]    zero, sup, dark;
    logic          pwm_ok;

    // Scan FSM and prescaler
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sel_d   = sel_q;
        if (!ce) begin
            state_d = StIdle;
            presc_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StGuard;
                    presc_d = '0;
                end
                StGuard: begin
                    presc_d = presc_q + 1'b1;
                    if (presc_q == GuardEnd) begin
                        state_d = StDrive;
                    end
                end
                StDrive: begin
                    if (presc_q == LastCnt) begin
                        presc_d = '0;
                        state_d = StGuard;
                        sel_d   = sel_q + 2'd1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    presc_d = '0;
                end
            endcase
        end
    end

    // Arbiter: a requester is ignored in the cycle its ack is high, so a held req
    // with fresh data is only sampled again one cycle later.
    always_comb begin
        vld0   = wr.req0 && !ack0_q;
        vld1   = wr.req1 && !ack1_q;
        gnt0   = vld0 && (!vld1 || !rr_q);
        gnt1   = vld1 && (!vld0 || rr_q);
        ack0_d = gnt0;
        ack1_d = gnt1;
        rr_d   = rr_q;
        if (gnt0) begin
            rr_d = 1'b1;
        end else if (gnt1) begin
            rr_d = 1'b0;
        end
        dig_d = dig_q;
        if (gnt0) begin
            dig_d[wr.wr0_digit] = wr.wr0_val;
        end else if (gnt1) begin
            dig_d[wr.wr1_digit] = wr.wr1_val;
        end
        x_d = dig_q[sel_q][3:0];
    end

    // Leading-zero suppression chains from digit 3 downward; digit 0 always shows.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            zero[i] = dig_q[i][4] || (dig_q[i][3:0] == 4'h0);
        end
        sup[3] = lzs_en && zero[3];
        sup[2] = sup[3] && zero[2];
        sup[1] = sup[2] && zero[1];
        sup[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dark[i] = dig_q[i][4] || sup[i];
        end
    end

`ifdef SEG_DIM_EN
    logic [2:0] pwm_q, pwm_d;

    always_comb begin
        pwm_d = pwm_q;
        if (state_d == StDrive && state_q != StDrive) begin
            pwm_d = '0;
        end else if (state_q == StDrive) begin
            pwm_d = pwm_q + 3'd1;
        end
        pwm_ok = ({1'b0, pwm_q} < ({1'b0, bright} + 4'd1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end
`else
    assign pwm_ok = 1'b1;
`endif

    always_comb begin
        AN = 4'b1111;
        if (state_q == StDrive && !dark[sel_q] && pwm_ok) begin
            AN[sel_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            presc_q <= '0;
            sel_q   <= '0;
            x_q     <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rr_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= 5'h10;
            end
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sel_q   <= sel_d;
            x_q     <= x_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rr_q    <= rr_d;
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= dig_d[i];
            end
        end
    end

    assign sel     = sel_q;
    assign x       = x_q;
    assign wr.ack0 = ack0_q;
    assign wr.ack1 = ack1_q;

endmodule
